// File: rtl/atm_session_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// atm_session_ctrl_pkg
// Shared encodings for the ATM session controller: request op codes, response
// codes, controller state encoding and a helper that sizes the failed-try
// counter from the lockout threshold.
// ----------------------------------------------------------------------------
package atm_session_ctrl_pkg;

    localparam int OP_W    = 3;
    localparam int RSP_W   = 3;
    localparam int STATE_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LOGIN      = 3'd0,
        OP_BALANCE    = 3'd1,
        OP_WITHDRAW   = 3'd2,
        OP_DEPOSIT    = 3'd3,
        OP_CHANGE_PIN = 3'd4,
        OP_EXIT       = 3'd5
    } op_t;

    typedef enum logic [RSP_W-1:0] {
        RSP_OK         = 3'd0,
        RSP_NO_ACC     = 3'd1,
        RSP_BAD_PIN    = 3'd2,
        RSP_LOCKED     = 3'd3,
        RSP_NO_FUNDS   = 3'd4,
        RSP_OVER_LIMIT = 3'd5,
        RSP_TIMEOUT    = 3'd6,
        RSP_REJECT     = 3'd7
    } rsp_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_MENU = 3'd1,
        ST_EXEC = 3'd2,
        ST_RESP = 3'd3
    } state_t;

    // Width needed to hold 0..maxTries, never less than one bit.
    function automatic int failWidth(input int maxTries);
        int w;
        w = $clog2(maxTries + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/atm_session_ctrl_account_store.sv
// ----------------------------------------------------------------------------
// atm_account_store
// Per-account storage of balance, PIN and consecutive failed-PIN count.
// One combinational read port (out-of-range addresses read as zero and flag
// o_rdValid low) and one synchronous write port that updates all three fields
// of an account at once. Reset loads the factory balances and PINs.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   i_rdAddr              account to read
//   o_rdBal/Pin/Fail      stored fields of i_rdAddr
//   o_rdValid             i_rdAddr names an existing account
//   i_we, i_wrAddr        write strobe and target account
//   i_wrBal/Pin/Fail      new field values
// ----------------------------------------------------------------------------
module atm_account_store
    import atm_session_ctrl_pkg::*;
#(
    parameter int               NUM_ACC  = 10,
    parameter int               ACC_W    = 4,
    parameter int               PIN_W    = 16,
    parameter int               BAL_W    = 32,
    parameter logic [PIN_W-1:0] PIN_BASE = 'h1000,
    parameter int               FAIL_W   = failWidth(3)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ACC_W-1:0]  i_rdAddr,
    output logic [BAL_W-1:0]  o_rdBal,
    output logic [PIN_W-1:0]  o_rdPin,
    output logic [FAIL_W-1:0] o_rdFail,
    output logic              o_rdValid,
    input  logic              i_we,
    input  logic [ACC_W-1:0]  i_wrAddr,
    input  logic [BAL_W-1:0]  i_wrBal,
    input  logic [PIN_W-1:0]  i_wrPin,
    input  logic [FAIL_W-1:0] i_wrFail
);

    logic [BAL_W-1:0]  r_bal  [NUM_ACC];
    logic [PIN_W-1:0]  r_pin  [NUM_ACC];
    logic [FAIL_W-1:0] r_fail [NUM_ACC];

    logic w_rdInRange;
    logic w_wrInRange;

    assign w_rdInRange = (int'(i_rdAddr) < NUM_ACC);
    assign w_wrInRange = (int'(i_wrAddr) < NUM_ACC);

    // Non-existent accounts read back as zero so the controller never sees X.
    assign o_rdValid = w_rdInRange;
    assign o_rdBal   = w_rdInRange ? r_bal[i_rdAddr]  : '0;
    assign o_rdPin   = w_rdInRange ? r_pin[i_rdAddr]  : '0;
    assign o_rdFail  = w_rdInRange ? r_fail[i_rdAddr] : '0;

    // Account i starts with 1000*(i+1) and PIN PIN_BASE+i; writes to
    // non-existent accounts are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_bal[i]  <= BAL_W'(1000 * (i + 1));
                r_pin[i]  <= PIN_BASE + PIN_W'(i);
                r_fail[i] <= '0;
            end
        end else if (i_we && w_wrInRange) begin
            r_bal[i_wrAddr]  <= i_wrBal;
            r_pin[i_wrAddr]  <= i_wrPin;
            r_fail[i_wrAddr] <= i_wrFail;
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ----------------------------------------------------------------------------
// atm_session_ctrl
// ATM session controller. Accepts one request at a time over valid/ready,
// evaluates it against the account store in EXEC, commits any update at the
// end of EXEC and presents a one-cycle response pulse in RESP. Tracks the
// logged-in account, the cumulative withdrawal of the session and an idle
// counter that forces a logout after TIMEOUT_CYC quiet cycles in MENU.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   req_valid    request present; req_ready high in IDLE and MENU
//   op           0 LOGIN,1 BALANCE,2 WITHDRAW,3 DEPOSIT,4 CHANGE_PIN,5 EXIT
//   acc_num,pin  LOGIN account and PIN; new_pin for CHANGE_PIN
//   amount       WITHDRAW/DEPOSIT amount
//   rsp_valid    one-cycle response pulse with rsp_code
//   balance      session account balance after the last operation
//   state        0 IDLE,1 MENU,2 EXEC,3 RESP
// ----------------------------------------------------------------------------
module atm_session_ctrl
    import atm_session_ctrl_pkg::*;
#(
    parameter int               NUM_ACC     = 10,
    parameter int               ACC_W       = 4,
    parameter int               PIN_W       = 16,
    parameter int               BAL_W       = 32,
    parameter logic [PIN_W-1:0] PIN_BASE    = 'h1000,
    parameter int               MAX_TRIES   = 3,
    parameter int               WD_LIMIT    = 5000,
    parameter int               TIMEOUT_CYC = 1024
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [ACC_W-1:0]   acc_num,
    input  logic [PIN_W-1:0]   pin,
    input  logic [PIN_W-1:0]   new_pin,
    input  logic [BAL_W-1:0]   amount,
    output logic               rsp_valid,
    output logic [RSP_W-1:0]   rsp_code,
    output logic [BAL_W-1:0]   balance,
    output logic [STATE_W-1:0] state
);

    localparam int                FAIL_W       = failWidth(MAX_TRIES);
    localparam int                CNT_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FAIL_W-1:0] MAX_TRIES_V  = FAIL_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BAL_W+1:0]  WD_LIMIT_EXT = (BAL_W + 2)'(WD_LIMIT);

    state_t             r_state;
    logic               r_reqReady;
    logic               r_rspValid;
    rsp_t               r_rspCode;
    logic [BAL_W-1:0]   r_balance;
    logic               r_loggedIn;
    logic [ACC_W-1:0]   r_curAcc;
    logic [OP_W-1:0]    r_op;
    logic [PIN_W-1:0]   r_pin;
    logic [PIN_W-1:0]   r_newPin;
    logic [BAL_W-1:0]   r_amount;
    logic [BAL_W:0]     r_sessionWd;
    logic [CNT_W-1:0]   r_idleCnt;

    logic [BAL_W-1:0]   w_rdBal;
    logic [PIN_W-1:0]   w_rdPin;
    logic [FAIL_W-1:0]  w_rdFail;
    logic               w_accOk;
    logic               w_we;
    logic               w_commit;
    logic [BAL_W-1:0]   w_wrBal;
    logic [PIN_W-1:0]   w_wrPin;
    logic [FAIL_W-1:0]  w_wrFail;
    rsp_t               w_rspCode;
    logic               w_nextLoggedIn;
    logic [BAL_W:0]     w_nextWd;
    logic               w_showBal;
    logic [BAL_W:0]     w_depSum;
    logic [BAL_W+1:0]   w_wdSum;

    // r_curAcc is the login target while logged out and the session account
    // once logged in, so a single read/write address serves both cases.
    atm_account_store #(
        .NUM_ACC  (NUM_ACC),
        .ACC_W    (ACC_W),
        .PIN_W    (PIN_W),
        .BAL_W    (BAL_W),
        .PIN_BASE (PIN_BASE),
        .FAIL_W   (FAIL_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .i_rdAddr  (r_curAcc),
        .o_rdBal   (w_rdBal),
        .o_rdPin   (w_rdPin),
        .o_rdFail  (w_rdFail),
        .o_rdValid (w_accOk),
        .i_we      (w_commit),
        .i_wrAddr  (r_curAcc),
        .i_wrBal   (w_wrBal),
        .i_wrPin   (w_wrPin),
        .i_wrFail  (w_wrFail)
    );

    // Extra top bits expose the deposit carry and keep the withdrawal
    // running total from wrapping before it is compared with the limit.
    assign w_depSum = {1'b0, w_rdBal} + {1'b0, r_amount};
    assign w_wdSum  = {1'b0, r_sessionWd} + {2'b00, r_amount};
    assign w_commit = w_we && (r_state == ST_EXEC);

    // Request evaluation. Field writes default to the stored values so a
    // commit only changes what the operation means to change.
    always_comb begin
        w_rspCode      = RSP_REJECT;
        w_we           = 1'b0;
        w_wrBal        = w_rdBal;
        w_wrPin        = w_rdPin;
        w_wrFail       = w_rdFail;
        w_nextLoggedIn = r_loggedIn;
        w_nextWd       = r_sessionWd;
        w_showBal      = 1'b0;
        if (!r_loggedIn) begin
            if (r_op != OP_LOGIN) begin
                w_rspCode = RSP_REJECT;
            end else if (!w_accOk) begin
                w_rspCode = RSP_NO_ACC;
            end else if (w_rdFail == MAX_TRIES_V) begin
                // Locked accounts refuse even the correct PIN.
                w_rspCode = RSP_LOCKED;
            end else if (r_pin != w_rdPin) begin
                w_rspCode = RSP_BAD_PIN;
                w_we      = 1'b1;
                w_wrFail  = w_rdFail + FAIL_W'(1);
            end else begin
                w_rspCode      = RSP_OK;
                w_we           = 1'b1;
                w_wrFail       = '0;
                w_nextLoggedIn = 1'b1;
                w_nextWd       = '0;
                w_showBal      = 1'b1;
            end
        end else begin
            w_showBal = 1'b1;
            case (r_op)
                OP_BALANCE: begin
                    w_rspCode = RSP_OK;
                end
                OP_WITHDRAW: begin
                    if (r_amount > w_rdBal) begin
                        w_rspCode = RSP_NO_FUNDS;
                    end else if (w_wdSum > WD_LIMIT_EXT) begin
                        w_rspCode = RSP_OVER_LIMIT;
                    end else begin
                        w_rspCode = RSP_OK;
                        w_we      = 1'b1;
                        w_wrBal   = w_rdBal - r_amount;
                        w_nextWd  = w_wdSum[BAL_W:0];
                    end
                end
                OP_DEPOSIT: begin
                    if (w_depSum[BAL_W]) begin
                        w_rspCode = RSP_REJECT;
                    end else begin
                        w_rspCode = RSP_OK;
                        w_we      = 1'b1;
                        w_wrBal   = w_depSum[BAL_W-1:0];
                    end
                end
                OP_CHANGE_PIN: begin
                    w_rspCode = RSP_OK;
                    w_we      = 1'b1;
                    w_wrPin   = r_newPin;
                end
                OP_EXIT: begin
                    w_rspCode      = RSP_OK;
                    w_nextLoggedIn = 1'b0;
                end
                default: begin
                    w_rspCode = RSP_REJECT;
                end
            endcase
        end
    end

    // Session FSM with registered outputs. The idle counter only advances
    // in MENU; a request arriving in the final idle cycle is accepted rather
    // than timed out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_reqReady  <= 1'b1;
            r_rspValid  <= 1'b0;
            r_rspCode   <= RSP_OK;
            r_balance   <= '0;
            r_loggedIn  <= 1'b0;
            r_curAcc    <= '0;
            r_op        <= '0;
            r_pin       <= '0;
            r_newPin    <= '0;
            r_amount    <= '0;
            r_sessionWd <= '0;
            r_idleCnt   <= '0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op       <= op;
                        r_curAcc   <= acc_num;
                        r_pin      <= pin;
                        r_newPin   <= new_pin;
                        r_amount   <= amount;
                        r_state    <= ST_EXEC;
                        r_reqReady <= 1'b0;
                    end
                end
                ST_MENU: begin
                    if (req_valid) begin
                        r_op       <= op;
                        r_pin      <= pin;
                        r_newPin   <= new_pin;
                        r_amount   <= amount;
                        r_idleCnt  <= '0;
                        r_state    <= ST_EXEC;
                        r_reqReady <= 1'b0;
                    end else if (r_idleCnt == CNT_LAST) begin
                        r_idleCnt  <= '0;
                        r_loggedIn <= 1'b0;
                        r_rspCode  <= RSP_TIMEOUT;
                        r_rspValid <= 1'b1;
                        r_state    <= ST_RESP;
                        r_reqReady <= 1'b0;
                    end else begin
                        r_idleCnt <= r_idleCnt + CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    r_state     <= ST_RESP;
                    r_rspValid  <= 1'b1;
                    r_rspCode   <= w_rspCode;
                    r_loggedIn  <= w_nextLoggedIn;
                    r_sessionWd <= w_nextWd;
                    if (w_showBal) begin
                        r_balance <= w_wrBal;
                    end
                end
                ST_RESP: begin
                    r_state    <= r_loggedIn ? ST_MENU : ST_IDLE;
                    r_reqReady <= 1'b1;
                    r_idleCnt  <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_reqReady <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_reqReady;
    assign rsp_valid = r_rspValid;
    assign rsp_code  = r_rspCode;
    assign balance   = r_balance;
    assign state     = r_state;

endmodule
